// File: rtl/irq_controller.sv
// Interrupt front end for the multicycle MIPS control FSM: edge detect, pending/mask,
// fixed priority, request/ack/RFE handshake and handler vector. Define IRQ_SYNC_EN to add input synchronizers.
module irq_controller #(
  parameter int          N_IRQ     = 4,
  parameter logic [31:0] VEC_BASE  = 32'h0000_0100,
  parameter int          VEC_SHIFT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  input  logic             int_ack,
  input  logic             rfe,
  output logic             int_sig,
  output logic [31:0]      int_vector,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] mask,
  output logic             in_service
);

  localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

  state_t           state_q, state_d;
  logic [N_IRQ-1:0] irq_s, irq_q, irq_rise, active, clr;
  logic [ID_W-1:0]  winner, isr_id_q, isr_id_d, vec_id;
  logic             any_active;

`ifdef IRQ_SYNC_EN
  logic [N_IRQ-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_in;
      sync2_q <= sync1_q;
    end
  end

  assign irq_s = sync2_q;
`else
  assign irq_s = irq_in;
`endif

  assign irq_rise   = irq_s & ~irq_q;
  assign active     = pending & mask;
  assign any_active = |active;

  // Scan from the top so the lowest active index is the last one written.
  always_comb begin
    winner = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (active[i]) winner = ID_W'(i);
    end
  end

  // NOTE: every output of this block gets a default before the case, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    isr_id_d = isr_id_q;
    clr      = '0;
    case (state_q)
      IDLE: if (any_active) state_d = IDLE == IDLE ? REQ : IDLE;
      REQ: begin
        // An ack with nothing left active has no line to service and is dropped.
        if (int_ack && any_active) begin
          isr_id_d    = winner;
          clr[winner] = 1'b1;
          state_d     = SVC;
        end else if (!any_active) begin
          state_d = IDLE;
        end
      end
      SVC:     if (rfe) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      isr_id_q   <= '0;
      irq_q      <= '0;
      pending    <= '0;
      mask       <= '1;
      int_sig    <= 1'b0;
      in_service <= 1'b0;
    end else begin
      state_q    <= state_d;
      isr_id_q   <= isr_id_d;
      irq_q      <= irq_s;
      pending    <= (pending & ~clr) | irq_rise;
      if (mask_we) mask <= mask_wdata;
      int_sig    <= (state_d == REQ);
      in_service <= (state_d == SVC);
    end
  end

  // The latched id holds the vector steady from the ack edge until the next request.
  assign vec_id     = (state_q == REQ) ? winner : isr_id_q;
  assign int_vector = VEC_BASE + (32'(vec_id) << VEC_SHIFT);

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed handshake scenarios, then random
// stimulus compared every cycle against a behavioural model of the interrupt rules.
module tb_irq_controller;

  localparam int          N      = 4;
  localparam logic [31:0] BASE   = 32'h0000_0100;
  localparam logic [31:0] STRIDE = 32'h10;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  irq_in;
  logic          mask_we;
  logic [N-1:0]  mask_wdata;
  logic          int_ack;
  logic          rfe;
  logic          int_sig;
  logic [31:0]   int_vector;
  logic [N-1:0]  pending;
  logic [N-1:0]  mask;
  logic          in_service;

  irq_controller #(.N_IRQ(N), .VEC_BASE(BASE), .VEC_SHIFT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .int_ack    (int_ack),
    .rfe        (rfe),
    .int_sig    (int_sig),
    .int_vector (int_vector),
    .pending    (pending),
    .mask       (mask),
    .in_service (in_service)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: per-line flags plus "requesting"/"serving" flags and the serviced line.
  bit m_pend[N];
  bit m_mask[N];
  bit m_last[N];
  bit m_s1[N];
  bit m_s2[N];
  bit m_req;
  bit m_svc;
  int m_id;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int lowest_active();
    for (int i = 0; i < N; i++) begin
      if (m_pend[i] && m_mask[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] pack(input bit v[N]);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = v[i];
    return r;
  endfunction

  task automatic model_clock(input logic [N-1:0] irq, input logic we, input logic [N-1:0] wd,
                             input logic ack, input logic rf, input logic rs);
    bit rise[N];
    int w;
    if (rs) begin
      for (int i = 0; i < N; i++) begin
        m_pend[i] = 0; m_mask[i] = 1; m_last[i] = 0; m_s1[i] = 0; m_s2[i] = 0;
      end
      m_req = 0; m_svc = 0; m_id = 0;
      return;
    end
    for (int i = 0; i < N; i++) begin
`ifdef IRQ_SYNC_EN
      rise[i]   = m_s2[i] && !m_last[i];
      m_last[i] = m_s2[i];
      m_s2[i]   = m_s1[i];
      m_s1[i]   = irq[i];
`else
      rise[i]   = irq[i] && !m_last[i];
      m_last[i] = irq[i];
`endif
    end
    w = lowest_active();
    if (m_req) begin
      if (ack && w >= 0) begin
        m_id = w; m_pend[w] = 0; m_req = 0; m_svc = 1;
      end else if (w < 0) begin
        m_req = 0;
      end
    end else if (m_svc) begin
      if (rf) m_svc = 0;
    end else if (w >= 0) begin
      m_req = 1;
    end
    for (int i = 0; i < N; i++) if (rise[i]) m_pend[i] = 1;
    if (we) for (int i = 0; i < N; i++) m_mask[i] = wd[i];
  endtask

  task automatic compare_all();
    int w;
    check("int_sig", 32'(int_sig), 32'(m_req));
    check("in_service", 32'(in_service), 32'(m_svc));
    check("pending", 32'(pending), 32'(pack(m_pend)));
    check("mask", 32'(mask), 32'(pack(m_mask)));
    w = lowest_active();
    if (!m_req) check("int_vector", int_vector, BASE + STRIDE * 32'(m_id));
    else if (w >= 0) check("int_vector", int_vector, BASE + STRIDE * 32'(w));
  endtask

  // One clock: inputs applied away from the edge, model advanced, outputs checked on the falling edge.
  task automatic step(input logic [N-1:0] irq, input logic we = 1'b0, input logic [N-1:0] wd = '0,
                      input logic ack = 1'b0, input logic rf = 1'b0, input logic rs = 1'b0);
    irq_in = irq; mask_we = we; mask_wdata = wd; int_ack = ack; rfe = rf; rst = rs;
    @(posedge clk);
    model_clock(irq, we, wd, ack, rf, rs);
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    irq_in = '0; mask_we = 0; mask_wdata = '0; int_ack = 0; rfe = 0; rst = 1;
    step(4'b0000, 0, 0, 0, 0, 1);
    step(4'b0000, 0, 0, 0, 0, 1);
    check("reset_pending", 32'(pending), 32'h0);
    check("reset_mask", 32'(mask), 32'hF);
    check("reset_int_sig", 32'(int_sig), 32'h0);
    check("reset_in_service", 32'(in_service), 32'h0);
    check("reset_vector", int_vector, 32'h100);
    step(4'b0000);

`ifndef IRQ_SYNC_EN
    // Single line 2 request and service.
    step(4'b0100);
    check("l2_pending", 32'(pending), 32'h4);
    check("l2_int_sig_early", 32'(int_sig), 32'h0);
    step(4'b0000);
    check("l2_int_sig", 32'(int_sig), 32'h1);
    check("l2_vector", int_vector, 32'h120);
    step(4'b0000, 0, 0, 1);
    check("l2_in_service", 32'(in_service), 32'h1);
    step(4'b0000, 0, 0, 0, 1);

    // Lines 1 and 3 together: 1 wins, 3 re-requests after rfe.
    step(4'b1010);
    step(4'b0000);
    check("pri_vector_req", int_vector, 32'h110);
    step(4'b0000, 0, 0, 1);
    check("pri_pending", 32'(pending), 32'h8);
    check("pri_in_service", 32'(in_service), 32'h1);
    check("pri_vector_svc", int_vector, 32'h110);
    step(4'b0000, 0, 0, 0, 1);
    check("pri_idle", 32'(int_sig), 32'h0);
    step(4'b0000);
    check("pri_rereq", 32'(int_sig), 32'h1);
    check("pri_vector_l3", int_vector, 32'h130);
    step(4'b0000, 0, 0, 1);
    step(4'b0000, 0, 0, 0, 1);

    // Masked line latches pending but does not request until unmasked.
    step(4'b0000, 1, 4'b1110);
    step(4'b0001);
    check("mask_pending", 32'(pending), 32'h1);
    step(4'b0000);
    step(4'b0000);
    check("mask_no_req", 32'(int_sig), 32'h0);
    step(4'b0000, 1, 4'b1111);
    check("mask_late", 32'(int_sig), 32'h0);
    step(4'b0000);
    check("unmask_req", 32'(int_sig), 32'h1);
    check("unmask_vector", int_vector, 32'h100);
    step(4'b0000, 0, 0, 1);
    step(4'b0000, 0, 0, 0, 1);

    // Masking the requesting line withdraws the request but keeps it pending.
    step(4'b0100);
    step(4'b0000);
    step(4'b0000, 1, 4'b1011);
    step(4'b0000);
    check("withdraw_int_sig", 32'(int_sig), 32'h0);
    check("withdraw_pending", 32'(pending), 32'h4);
    step(4'b0000, 1, 4'b1111);
    step(4'b0000);
    step(4'b0000, 0, 0, 1);
    step(4'b0000, 0, 0, 0, 1);

    // New edge on line 0 coincident with its ack stays pending and re-requests after rfe.
    step(4'b0001);
    step(4'b0000);
    step(4'b0001, 0, 0, 1);
    check("coincide_pending", 32'(pending), 32'h1);
    check("coincide_in_service", 32'(in_service), 32'h1);
    step(4'b0000, 0, 0, 0, 1);
    step(4'b0000);
    check("coincide_rereq", 32'(int_sig), 32'h1);
    step(4'b0000, 0, 0, 1);
    step(4'b0000, 0, 0, 0, 1);
`else
    // Synchronized input: pending two edges later, then reset in service.
    step(4'b0001);
    check("sync_k", 32'(pending), 32'h0);
    step(4'b0001);
    check("sync_k1", 32'(pending), 32'h0);
    step(4'b0000);
    check("sync_k2", 32'(pending), 32'h1);
    check("sync_k2_int_sig", 32'(int_sig), 32'h0);
    step(4'b0000);
    check("sync_k3_int_sig", 32'(int_sig), 32'h1);
    step(4'b0000, 0, 0, 1);
    step(4'b0010);
    step(4'b0000);
    step(4'b0000);
    check("sync_svc_pending", 32'(pending), 32'h2);
    step(4'b0000, 0, 0, 0, 0, 1);
    check("rst_svc_in_service", 32'(in_service), 32'h0);
    check("rst_svc_pending", 32'(pending), 32'h0);
`endif

    // Random traffic against the model, including occasional resets mid-flight.
    for (int n = 0; n < 600; n++) begin
      step(4'($urandom),
           $urandom_range(0, 11) == 0,
           4'($urandom),
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 80) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
